// File: rtl/proc_iter_engine.sv
// Iterative accumulate engine: on START it runs niter iterations at one per clock.
// Each iteration updates a linear accumulator and a square accumulator from a stepped x.
module proc_iter_engine #(
   parameter int CNT_W  = 32,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              nRESET,
   input  logic [3:0]        proc_cmd,
   input  logic [CNT_W-1:0]  niter,
   input  logic [DATA_W-1:0] constK,
   input  logic [DATA_W-1:0] const1,
   input  logic [DATA_W-1:0] const2,
   output logic [3:0]        proc_status,
   output logic [DATA_W-1:0] proc_acc_dout,
   output logic [DATA_W-1:0] proc_pow_acc_dout,
   output logic [CNT_W-1:0]  iter_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_DONE    = 2'd2,
      ST_ABORTED = 2'd3
   } state_t;

   localparam logic [3:0] CMD_START = 4'h1;
   localparam logic [3:0] CMD_ABORT = 4'h2;
   localparam logic [3:0] CMD_CLEAR = 4'h3;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] pow_q, pow_d;
   logic [DATA_W-1:0] x_q, x_d;
   logic [DATA_W-1:0] k2_q, k2_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [3:0]        cmd_prev_q;

   logic              cmd_ev;
   logic [CNT_W-1:0]  cnt_inc;
   logic [63:0]       x_lo;
   logic [63:0]       sq;

   assign cmd_ev  = (proc_cmd != cmd_prev_q);
   assign cnt_inc = cnt_q + 1'b1;
   // Square uses only the low 32 bits of x, giving an exact 64-bit product.
   assign x_lo    = {32'b0, x_q[31:0]};
   assign sq      = x_lo * x_lo;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      pow_d   = pow_q;
      x_d     = x_q;
      k2_d    = k2_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      case (state_q)
         ST_BUSY: begin
            // Abort wins over the iteration of the same edge, including the last one.
            if (cmd_ev && proc_cmd == CMD_ABORT) begin
               state_d = ST_ABORTED;
            end else begin
               acc_d = acc_q + x_q;
               pow_d = pow_q + DATA_W'(sq);
               x_d   = x_q + k2_q;
               cnt_d = cnt_inc;
               if (cnt_inc == n_q) state_d = ST_DONE;
            end
         end
         default: begin
            if (cmd_ev && proc_cmd == CMD_START) begin
               acc_d   = constK;
               pow_d   = '0;
               x_d     = const1;
               n_d     = niter;
               k2_d    = const2;
               cnt_d   = '0;
               state_d = (niter == '0) ? ST_DONE : ST_BUSY;
            end else if (cmd_ev && proc_cmd == CMD_CLEAR) begin
               acc_d   = '0;
               pow_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nRESET) begin
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         pow_q      <= '0;
         x_q        <= '0;
         k2_q       <= '0;
         cnt_q      <= '0;
         n_q        <= '0;
         cmd_prev_q <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         pow_q      <= pow_d;
         x_q        <= x_d;
         k2_q       <= k2_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         cmd_prev_q <= proc_cmd;
      end
   end

   assign proc_status       = {2'b0, state_q};
   assign proc_acc_dout     = acc_q;
   assign proc_pow_acc_dout = pow_q;
   assign iter_cnt          = cnt_q;

endmodule

// File: tb/tb_proc_iter_engine.sv
// Directed plus randomized bench for proc_iter_engine, checked against a closed-form/loop model.
module tb_proc_iter_engine;

   logic        clk = 1'b0;
   logic        nRESET;
   logic [3:0]  proc_cmd;
   logic [31:0] niter;
   logic [63:0] constK, const1, const2;
   logic [3:0]  proc_status;
   logic [63:0] proc_acc_dout, proc_pow_acc_dout;
   logic [31:0] iter_cnt;

   int total = 0;
   int bad   = 0;

   proc_iter_engine #(.CNT_W(32), .DATA_W(64)) dut (
      .clk(clk), .nRESET(nRESET), .proc_cmd(proc_cmd), .niter(niter),
      .constK(constK), .const1(const1), .const2(const2),
      .proc_status(proc_status), .proc_acc_dout(proc_acc_dout),
      .proc_pow_acc_dout(proc_pow_acc_dout), .iter_cnt(iter_cnt)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected results after m iterations: acc in closed form, pow as a sum of squares.
   task automatic model(input logic [63:0] k, input logic [63:0] c1, input logic [63:0] c2,
                        input int m, output logic [63:0] acc, output logic [63:0] pow);
      logic [63:0] xi, lo, tri_n;
      tri_n = 64'(m) * 64'(m - 1) / 64'd2;
      acc   = k + 64'(m) * c1 + tri_n * c2;
      pow   = 64'd0;
      for (int i = 0; i < m; i++) begin
         xi  = c1 + 64'(i) * c2;
         lo  = {32'b0, xi[31:0]};
         pow = pow + lo * lo;
      end
   endtask

   // Returns sampled just after the edge that consumed the START event.
   task automatic start_run(input logic [63:0] k, input logic [63:0] c1, input logic [63:0] c2,
                            input logic [31:0] n);
      proc_cmd = 4'h0;
      tick();
      constK = k; const1 = c1; const2 = c2; niter = n;
      proc_cmd = 4'h1;
      tick();
   endtask

   task automatic chk_all(input string tag, input logic [3:0] st, input logic [63:0] acc,
                          input logic [63:0] pow, input logic [31:0] cnt);
      chk({tag, ".status"}, 64'(proc_status), 64'(st));
      chk({tag, ".acc"}, proc_acc_dout, acc);
      chk({tag, ".pow"}, proc_pow_acc_dout, pow);
      chk({tag, ".cnt"}, 64'(iter_cnt), 64'(cnt));
   endtask

   initial begin
      logic [63:0] ea, ep, k, c1, c2;
      int n, a;

      nRESET = 1'b0; proc_cmd = 4'h0; niter = '0;
      constK = '0; const1 = '0; const2 = '0;
      tick(2);
      chk_all("reset", 4'd0, 64'd0, 64'd0, 32'd0);
      nRESET = 1'b1;
      tick();

      // Basic run: 4 iterations of x = 1,2,3,4
      start_run(64'd0, 64'd1, 64'd1, 32'd4);
      chk("basic.busy0", 64'(proc_status), 64'd1);
      tick(3);
      chk("basic.busy3", 64'(proc_status), 64'd1);
      chk("basic.cnt3", 64'(iter_cnt), 64'd3);
      tick();
      chk_all("basic.done", 4'd2, 64'd10, 64'd30, 32'd4);

      // Held START level must not restart
      tick(3);
      chk_all("held", 4'd2, 64'd10, 64'd30, 32'd4);

      proc_cmd = 4'h3;
      tick();
      chk_all("clear", 4'd0, 64'd0, 64'd0, 32'd0);

      // Zero iteration count completes immediately
      start_run(64'd7, 64'd5, 64'd9, 32'd0);
      chk_all("zero", 4'd2, 64'd7, 64'd0, 32'd0);

      // Abort after 10 busy cycles
      start_run(64'd0, 64'd2, 64'd0, 32'd1000);
      tick(10);
      proc_cmd = 4'h2;
      tick();
      chk_all("abort", 4'd3, 64'd20, 64'd40, 32'd10);
      tick(5);
      chk_all("abort.hold", 4'd3, 64'd20, 64'd40, 32'd10);

      // START while BUSY is ignored
      start_run(64'd3, 64'd4, 64'd5, 32'd6);
      proc_cmd = 4'h0; tick();
      proc_cmd = 4'h1; tick();
      tick(3);
      chk("restart.busy", 64'(proc_status), 64'd1);
      tick();
      model(64'd3, 64'd4, 64'd5, 6, ea, ep);
      chk_all("restart.done", 4'd2, ea, ep, 32'd6);

      // CLEAR in BUSY ignored
      start_run(64'd1, 64'd1, 64'd1, 32'd3);
      proc_cmd = 4'h3; tick();
      chk("clr_busy", 64'(proc_status), 64'd1);
      tick(2);
      model(64'd1, 64'd1, 64'd1, 3, ea, ep);
      chk_all("clr_busy.done", 4'd2, ea, ep, 32'd3);

      // Wrap of acc
      start_run(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'd1);
      tick();
      chk_all("wrap", 4'd2, 64'd0, 64'd1, 32'd1);

      // Abort on the final edge resolves as abort
      start_run(64'd0, 64'd7, 64'd1, 32'd5);
      tick(4);
      proc_cmd = 4'h2; tick();
      model(64'd0, 64'd7, 64'd1, 4, ea, ep);
      chk_all("abort_last", 4'd3, ea, ep, 32'd4);

      // Randomized runs, inputs scrambled during BUSY, optional abort
      for (int r = 0; r < 10; r++) begin
         k  = {$urandom, $urandom};
         c1 = {$urandom, $urandom};
         c2 = {$urandom, $urandom};
         n  = int'($urandom_range(1, 20));
         start_run(k, c1, c2, 32'(n));
         constK = {$urandom, $urandom}; const1 = {$urandom, $urandom};
         const2 = {$urandom, $urandom}; niter = $urandom;
         if (r % 2 == 1) begin
            a = int'($urandom_range(0, n - 1));
            tick(a);
            proc_cmd = 4'h2; tick();
            model(k, c1, c2, a, ea, ep);
            chk_all($sformatf("rnd%0d.abort", r), 4'd3, ea, ep, 32'(a));
         end else begin
            tick(n);
            model(k, c1, c2, n, ea, ep);
            chk_all($sformatf("rnd%0d.done", r), 4'd2, ea, ep, 32'(n));
         end
      end

      // Reset in the middle of a run
      start_run(64'd9, 64'd3, 64'd2, 32'd100);
      tick(5);
      chk("midrst.cnt5", 64'(iter_cnt), 64'd5);
      nRESET = 1'b0; proc_cmd = 4'h0;
      tick();
      chk_all("midrst", 4'd0, 64'd0, 64'd0, 32'd0);
      nRESET = 1'b1;
      tick(3);
      chk_all("midrst.after", 4'd0, 64'd0, 64'd0, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/proc_iter_engine.md
Name: proc_iter_engine

Overview:
- Compute stage directly downstream of the host register interface.
- Consumes the command nibble, iteration count and three 64-bit constants produced by the host interface.
- Runs an iterative accumulate loop at one iteration per clock.
- Returns a 4-bit status plus two 64-bit accumulators, which the host interface reads back and drives onto the 7-segment display.

Parameters:
- CNT_W, 32, width of niter and of the iteration counter.
- DATA_W, 64, width of constants and accumulators.

Ports:
- clk  input  1  system clock.
- nRESET  input  1  synchronous, active-low reset, sampled on rising clk.
- proc_cmd  input  4  host command level (held by host until rewritten).
- niter  input  CNT_W  iteration count, latched at start.
- constK  input  DATA_W  initial value of acc.
- const1  input  DATA_W  initial value of x.
- const2  input  DATA_W  per-iteration increment of x.
- proc_status  output  4  0=IDLE, 1=BUSY, 2=DONE, 3=ABORTED.
- proc_acc_dout  output  DATA_W  linear accumulator.
- proc_pow_acc_dout  output  DATA_W  square accumulator.
- iter_cnt  output  CNT_W  iterations completed in the current or last run.

Behaviour:
- One clock; reset is synchronous and active-low (clk, nRESET). No asynchronous logic.
- Reset (nRESET=0 at a rising edge):
  - state=IDLE, proc_status=0.
  - acc, pow_acc, x, iter_cnt, latched niter, latched const2 all 0.
  - cmd_prev=0.
  - Reset mid-run abandons the run with no further updates.
- Command decode:
  - cmd_prev is a registered copy of proc_cmd.
  - A command event occurs on a cycle where proc_cmd != cmd_prev; the value acted on is proc_cmd.
  - A held level never retriggers. The host must write a different value (e.g. 0) before repeating a command.
- Commands:
  - 4'h1 START: accepted in IDLE, DONE or ABORTED. At that edge: acc<=constK, pow_acc<=0, x<=const1, n_lat<=niter, k2_lat<=const2, iter_cnt<=0. If niter==0, state<=DONE; otherwise state<=BUSY.
  - 4'h2 ABORT: in BUSY, state<=ABORTED. Accumulators and iter_cnt freeze at their values after the last completed iteration; the iteration of the abort cycle is not performed. Ignored in other states.
  - 4'h3 CLEAR: in IDLE, DONE or ABORTED, acc, pow_acc and iter_cnt <=0 and state<=IDLE. Ignored in BUSY.
  - All other values, or any command not listed for the current state (including START while BUSY): no effect.
- BUSY, each cycle without an abort event:
  - acc <= acc + x (mod 2^DATA_W).
  - pow_acc <= pow_acc + {32'b0, x[31:0]} * {32'b0, x[31:0]}, full 64-bit product, sum mod 2^64.
  - x <= x + k2_lat (mod 2^64).
  - iter_cnt <= iter_cnt + 1.
  - When iter_cnt+1 == n_lat, state<=DONE on the same edge.
- Latency: START event sampled at edge E. First iteration at edge E+1. Last iteration and DONE both at edge E+niter. proc_status reads 2 from then on.
- Inputs: constants and niter changing during BUSY have no effect, since all are latched at start.
- Outputs: all registered, no combinational path from inputs. proc_status = {2'b0, state}. Outputs hold in DONE/ABORTED until CLEAR or START.
- Overflow: wraps silently, no saturation, no flag.
- Simultaneous events: the final iteration and an ABORT event on the same edge resolve as ABORT; the final iteration is not applied and status=3.

Test Plan:
- Reset then idle: nRESET low 2 cycles -> status 0, both accumulators 0, iter_cnt 0.
- Basic run: constK=0, const1=1, const2=1, niter=4, proc_cmd 0->1 -> BUSY 4 cycles, then status 2, acc=10, pow_acc=30, iter_cnt=4, DONE exactly 4 edges after the event.
- Zero count: niter=0, constK=7, cmd 0->1 -> status 2 next edge, acc=7, pow_acc=0, iter_cnt=0.
- Abort: niter=1000, const1=2, const2=0, constK=0, START, ABORT after 10 busy cycles -> status 3, acc=20, pow_acc=40, iter_cnt=10; further cycles leave the values unchanged.
- Level/retrigger and ignored commands:
  - cmd held at 1 after DONE -> no restart.
  - cmd 1->3 -> IDLE, accumulators 0.
  - START during BUSY (1->0->1) -> ignored, run completes normally.
- Wrap and mid-run reset:
  - constK=2^64-1, const1=1, niter=1 -> acc=0.
  - nRESET asserted at iteration 5 of a 100-iteration run -> all outputs 0 next edge, status 0.
